// File: rtl/filt_iir_tdm_sched_if.sv
// Core-side bus of the TDM scheduler: issued sample plus channel select out,
// core result back in. The scheduler is the master, the shared IIR core the slave.
interface filt_iir_tdm_sched_if #(
    parameter int gp_nr_ch     = 4,
    parameter int gp_inp_width = 8,
    parameter int gp_oup_width = 32
);
    localparam int CW = $clog2(gp_nr_ch);

    logic                    o_core_ena;
    logic [CW-1:0]           o_core_sel;
    logic [gp_inp_width-1:0] o_core_data;
    logic [gp_oup_width-1:0] i_core_data;

    modport master (
        output o_core_ena,
        output o_core_sel,
        output o_core_data,
        input  i_core_data
    );

    modport slave (
        input  o_core_ena,
        input  o_core_sel,
        input  o_core_data,
        output i_core_data
    );
endinterface

// File: rtl/filt_iir_tdm_sched.sv
// Round-robin TDM scheduler sharing one IIR core among gp_nr_ch sample streams.
// Optional macro FILT_IIR_TDM_STAT_EN adds per-channel saturating issue counters (o_stat).
module filt_iir_tdm_sched #(
    parameter int gp_nr_ch        = 4,
    parameter int gp_inp_width    = 8,
    parameter int gp_oup_width    = 32,
    parameter int gp_core_latency = 1
) (
    input  logic                             i_clk,
    input  logic                             i_rst_an,
    input  logic                             i_ena,
    input  logic [gp_nr_ch-1:0]              i_req,
    input  logic [gp_nr_ch*gp_inp_width-1:0] i_data,
    filt_iir_tdm_sched_if.master             core,
    output logic                             o_valid,
    output logic [$clog2(gp_nr_ch)-1:0]      o_ch,
    output logic [gp_oup_width-1:0]          o_data,
    output logic [gp_nr_ch-1:0]              o_ovf,
    output logic                             o_busy
`ifdef FILT_IIR_TDM_STAT_EN
    ,
    output logic [gp_nr_ch*16-1:0]           o_stat
`endif
);
    localparam int CW = $clog2(gp_nr_ch);
    localparam int DW = $clog2(gp_core_latency + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    typedef struct packed {
        logic          ena;
        logic [CW-1:0] sel;
    } tag_t;

    state_t                  state_q, state_d;
    logic [gp_nr_ch-1:0]     pend_q, pend_d;
    logic [gp_nr_ch-1:0]     ovf_q, ovf_d;
    logic [gp_inp_width-1:0] buf_q [gp_nr_ch];
    logic [gp_inp_width-1:0] buf_d [gp_nr_ch];
    logic [CW-1:0]           rr_ptr_q, rr_ptr_d;
    logic [DW-1:0]           drain_cnt_q, drain_cnt_d;
    tag_t                    tag_q [gp_core_latency];
    tag_t                    tag_d [gp_core_latency];
    logic                    core_ena_q, core_ena_d;
    logic [CW-1:0]           core_sel_q, core_sel_d;
    logic [gp_inp_width-1:0] core_data_q, core_data_d;
    logic                    valid_q, valid_d;
    logic [CW-1:0]           ch_q, ch_d;
    logic [gp_oup_width-1:0] data_q, data_d;

    logic                    grant_en;
    logic                    gnt_found;
    logic [CW-1:0]           gnt_ch;
    logic                    grant;
    logic                    in_flight;

    // Round-robin search over pend_q starting at rr_ptr_q, wrapping at gp_nr_ch-1.
    always_comb begin
        logic [CW:0]   sum;
        logic [CW-1:0] idx;
        sum       = '0;
        idx       = '0;
        gnt_found = 1'b0;
        gnt_ch    = '0;
        for (int i = 0; i < gp_nr_ch; i++) begin
            sum = {1'b0, rr_ptr_q} + (CW+1)'(i);
            if (sum >= (CW+1)'(gp_nr_ch)) begin
                sum = sum - (CW+1)'(gp_nr_ch);
            end
            idx = sum[CW-1:0];
            if (!gnt_found && pend_q[idx]) begin
                gnt_found = 1'b1;
                gnt_ch    = idx;
            end
        end
    end

    assign grant = grant_en && gnt_found;

    always_comb begin
        in_flight = core_ena_q;
        for (int i = 0; i < gp_core_latency; i++) begin
            in_flight = in_flight | tag_q[i].ena;
        end
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        drain_cnt_d = drain_cnt_q;
        grant_en    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // The first grant happens in the same clock that leaves IDLE.
                if (i_ena && (|pend_q)) begin
                    grant_en = 1'b1;
                    state_d  = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!i_ena) begin
                    state_d     = ST_DRAIN;
                    drain_cnt_d = '0;
                end else if (|pend_q) begin
                    grant_en = 1'b1;
                end else if (in_flight) begin
                    state_d     = ST_DRAIN;
                    drain_cnt_d = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                if (drain_cnt_q == DW'(gp_core_latency)) begin
                    state_d = (i_ena && (|pend_q)) ? ST_RUN : ST_IDLE;
                end else begin
                    drain_cnt_d = drain_cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        pend_d      = pend_q;
        ovf_d       = ovf_q;
        buf_d       = buf_q;
        rr_ptr_d    = rr_ptr_q;
        core_ena_d  = grant;
        core_sel_d  = core_sel_q;
        core_data_d = core_data_q;

        if (grant) begin
            pend_d[gnt_ch] = 1'b0;
            rr_ptr_d       = (gnt_ch == CW'(gp_nr_ch - 1)) ? '0 : gnt_ch + 1'b1;
            core_sel_d     = gnt_ch;
            core_data_d    = buf_q[gnt_ch];
        end

        // A request on the channel being granted refills its buffer without overrun.
        for (int k = 0; k < gp_nr_ch; k++) begin
            if (i_req[k]) begin
                if (!pend_q[k] || (grant && (gnt_ch == CW'(k)))) begin
                    buf_d[k]  = i_data[k*gp_inp_width +: gp_inp_width];
                    pend_d[k] = 1'b1;
                end else begin
                    ovf_d[k] = 1'b1;
                end
            end
        end

        tag_d[0] = '{ena: core_ena_q, sel: core_sel_q};
        for (int i = 1; i < gp_core_latency; i++) begin
            tag_d[i] = tag_q[i-1];
        end

        valid_d = tag_q[gp_core_latency-1].ena;
        ch_d    = valid_d ? tag_q[gp_core_latency-1].sel : ch_q;
        data_d  = valid_d ? core.i_core_data : data_q;
    end

    // NOTE: sequential state is written only with non-blocking assignments.
    always_ff @(posedge i_clk or negedge i_rst_an) begin
        if (!i_rst_an) begin
            state_q     <= ST_IDLE;
            pend_q      <= '0;
            ovf_q       <= '0;
            rr_ptr_q    <= '0;
            drain_cnt_q <= '0;
            core_ena_q  <= 1'b0;
            core_sel_q  <= '0;
            core_data_q <= '0;
            valid_q     <= 1'b0;
            ch_q        <= '0;
            data_q      <= '0;
            // NOTE: the sample buffers and tag pipeline are reset so nothing in flight survives a reset.
            for (int k = 0; k < gp_nr_ch; k++) begin
                buf_q[k] <= '0;
            end
            for (int i = 0; i < gp_core_latency; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            pend_q      <= pend_d;
            ovf_q       <= ovf_d;
            rr_ptr_q    <= rr_ptr_d;
            drain_cnt_q <= drain_cnt_d;
            core_ena_q  <= core_ena_d;
            core_sel_q  <= core_sel_d;
            core_data_q <= core_data_d;
            valid_q     <= valid_d;
            ch_q        <= ch_d;
            data_q      <= data_d;
            buf_q       <= buf_d;
            tag_q       <= tag_d;
        end
    end

    assign core.o_core_ena  = core_ena_q;
    assign core.o_core_sel  = core_sel_q;
    assign core.o_core_data = core_data_q;
    assign o_valid          = valid_q;
    assign o_ch             = ch_q;
    assign o_data           = data_q;
    assign o_ovf            = ovf_q;
    assign o_busy           = (state_q == ST_RUN) || (state_q == ST_DRAIN);

`ifdef FILT_IIR_TDM_STAT_EN
    logic [15:0] stat_q [gp_nr_ch];
    logic [15:0] stat_d [gp_nr_ch];

    always_comb begin
        stat_d = stat_q;
        if (grant && (stat_q[gnt_ch] != 16'hFFFF)) begin
            stat_d[gnt_ch] = stat_q[gnt_ch] + 16'd1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_an) begin
        if (!i_rst_an) begin
            for (int k = 0; k < gp_nr_ch; k++) begin
                stat_q[k] <= '0;
            end
        end else begin
            stat_q <= stat_d;
        end
    end

    always_comb begin
        o_stat = '0;
        for (int k = 0; k < gp_nr_ch; k++) begin
            o_stat[k*16 +: 16] = stat_q[k];
        end
    end
`endif
endmodule

// File: tb/tb_filt_iir_tdm_sched.sv
// Directed bench for filt_iir_tdm_sched with a x3 core stub of latency 1.
// Expected values are hand-derived from the scheduling rules.
module tb_filt_iir_tdm_sched;
    localparam int NCH = 4;
    localparam int IW  = 8;
    localparam int OW  = 32;
    localparam int LAT = 1;

    logic              clk;
    logic              rst_n;
    logic              i_ena;
    logic [NCH-1:0]    i_req;
    logic [NCH*IW-1:0] i_data;
    logic              o_valid;
    logic [1:0]        o_ch;
    logic [OW-1:0]     o_data;
    logic [NCH-1:0]    o_ovf;
    logic              o_busy;
`ifdef FILT_IIR_TDM_STAT_EN
    logic [NCH*16-1:0] o_stat;
`endif

    filt_iir_tdm_sched_if #(.gp_nr_ch(NCH), .gp_inp_width(IW), .gp_oup_width(OW)) core_if ();

    filt_iir_tdm_sched #(
        .gp_nr_ch(NCH), .gp_inp_width(IW), .gp_oup_width(OW), .gp_core_latency(LAT)
    ) dut (
        .i_clk    (clk),
        .i_rst_an (rst_n),
        .i_ena    (i_ena),
        .i_req    (i_req),
        .i_data   (i_data),
        .core     (core_if.master),
        .o_valid  (o_valid),
        .o_ch     (o_ch),
        .o_data   (o_data),
        .o_ovf    (o_ovf),
        .o_busy   (o_busy)
`ifdef FILT_IIR_TDM_STAT_EN
        ,
        .o_stat   (o_stat)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Core stub: result = sign-extended sample * 3, one clock after the enable is sampled.
    always @(posedge clk) begin
        if (core_if.o_core_ena) begin
            core_if.i_core_data <= 32'(signed'(core_if.o_core_data)) * 32'd3;
        end
    end

    int cyc;
    int iss_sel[$], iss_data[$], iss_cyc[$];
    int res_ch[$], res_data[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (core_if.o_core_ena) begin
            iss_sel.push_back(int'(core_if.o_core_sel));
            iss_data.push_back(int'(core_if.o_core_data));
            iss_cyc.push_back(cyc);
        end
        if (o_valid) begin
            res_ch.push_back(int'(o_ch));
            res_data.push_back(int'(o_data));
        end
    end

    int n_checks;
    int n_fail;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_req(input logic [3:0] mask, input logic [7:0] d0, input logic [7:0] d1,
                           input logic [7:0] d2, input logic [7:0] d3);
        i_req  = mask;
        i_data = {d3, d2, d1, d0};
    endtask

    task automatic do_reset();
        i_req  = '0;
        i_data = '0;
        i_ena  = 1'b0;
        rst_n  = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(1);
    endtask

    task automatic check_iss(input string tag, input int idx, input int sel, input int data);
        if (idx < iss_sel.size()) begin
            check({tag, "_sel"}, iss_sel[idx], sel);
            check({tag, "_data"}, iss_data[idx], data);
        end else begin
            check({tag, "_present"}, iss_sel.size(), idx + 1);
        end
    endtask

    task automatic check_res(input string tag, input int idx, input int ch, input int data);
        if (idx < res_ch.size()) begin
            check({tag, "_ch"}, res_ch[idx], ch);
            check({tag, "_data"}, res_data[idx], data);
        end else begin
            check({tag, "_present"}, res_ch.size(), idx + 1);
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_core_ena"}, core_if.o_core_ena, 0);
        check({tag, "_core_sel"}, core_if.o_core_sel, 0);
        check({tag, "_core_data"}, core_if.o_core_data, 0);
        check({tag, "_valid"}, o_valid, 0);
        check({tag, "_ch"}, o_ch, 0);
        check({tag, "_data"}, o_data, 0);
        check({tag, "_ovf"}, o_ovf, 0);
        check({tag, "_busy"}, o_busy, 0);
`ifdef FILT_IIR_TDM_STAT_EN
        check({tag, "_stat"}, o_stat, 0);
`endif
    endtask

    initial begin
        int bi, br, req3_cyc;
        n_checks = 0;
        n_fail   = 0;
        cyc      = 0;
        i_req    = '0;
        i_data   = '0;
        i_ena    = 1'b0;
        rst_n    = 1'b1;
        #2;

        // Reset state
        do_reset();
        check_outputs_zero("rst");

        // 1: single request on ch2, sample 5
        i_ena = 1'b1;
        set_req(4'b0100, 0, 0, 8'sd5, 0);
        tick();
        i_req = '0;
        check("t1_ena_early", core_if.o_core_ena, 0);
        tick();
        check("t1_ena", core_if.o_core_ena, 1);
        check("t1_sel", core_if.o_core_sel, 2);
        check("t1_cdata", core_if.o_core_data, 5);
        check("t1_busy", o_busy, 1);
        tick();
        check("t1_ena_one_clk", core_if.o_core_ena, 0);
        check("t1_valid_early", o_valid, 0);
        tick();
        check("t1_valid", o_valid, 1);
        check("t1_ch", o_ch, 2);
        check("t1_data", o_data, 15);
        tick();
        check("t1_valid_one_clk", o_valid, 0);

        // 2: all channels at once, in-order issue from rr_ptr=0
        do_reset();
        i_ena = 1'b1;
        bi = iss_sel.size();
        br = res_ch.size();
        set_req(4'b1111, 1, 2, 3, 4);
        tick();
        i_req = '0;
        tick(8);
        check("t2_n_iss", iss_sel.size() - bi, 4);
        check("t2_n_res", res_ch.size() - br, 4);
        for (int k = 0; k < 4; k++) begin
            check_iss($sformatf("t2_iss%0d", k), bi + k, k, k + 1);
            check_res($sformatf("t2_res%0d", k), br + k, k, 3 * (k + 1));
        end
        if (bi + 3 < iss_cyc.size()) begin
            check("t2_back_to_back", iss_cyc[bi+3] - iss_cyc[bi], 3);
        end else begin
            check("t2_cyc_present", iss_cyc.size(), bi + 4);
        end
        // rr_ptr back at 0: ch0 must win over ch3
        bi = iss_sel.size();
        set_req(4'b1001, 7, 0, 0, 9);
        tick();
        i_req = '0;
        tick(6);
        check_iss("t2_rr0_first", bi, 0, 7);
        check_iss("t2_rr0_second", bi + 1, 3, 9);

        // 3: overrun with scheduler disabled
        do_reset();
        bi = iss_sel.size();
        br = res_ch.size();
        set_req(4'b0010, 0, 8'h11, 0, 0);
        tick();
        set_req(4'b0010, 0, 8'h22, 0, 0);
        tick();
        i_req = '0;
        tick();
        check("t3_ovf", o_ovf, 4'b0010);
        check("t3_no_issue", iss_sel.size() - bi, 0);
        check("t3_busy_idle", o_busy, 0);
        i_ena = 1'b1;
        tick(6);
        check("t3_n_iss", iss_sel.size() - bi, 1);
        check_iss("t3_iss", bi, 1, 8'h11);
        check_res("t3_res", br, 1, 8'h33);
        check("t3_ovf_sticky", o_ovf, 4'b0010);

        // 4: fairness, ch0 streaming while ch3 requests once
        do_reset();
        i_ena = 1'b1;
        bi = iss_sel.size();
        req3_cyc = 0;
        for (int j = 0; j < 4; j++) begin
            if (j == 3) begin
                set_req(4'b1001, 8'(10 + j), 0, 0, 50);
            end else begin
                set_req(4'b0001, 8'(10 + j), 0, 0, 0);
            end
            tick();
            if (j == 3) req3_cyc = cyc;
        end
        i_req = '0;
        tick(8);
        check("t4_n_iss", iss_sel.size() - bi, 5);
        check_iss("t4_iss0", bi, 0, 10);
        check_iss("t4_iss1", bi + 1, 0, 11);
        check_iss("t4_iss2", bi + 2, 0, 12);
        check_iss("t4_iss3", bi + 3, 3, 50);
        check_iss("t4_iss4", bi + 4, 0, 13);
        if (bi + 3 < iss_cyc.size()) begin
            check("t4_ch3_within_nr_ch", (iss_cyc[bi+3] - req3_cyc) <= NCH, 1);
        end
        check("t4_no_ovf", o_ovf, 0);

        // 5: enable dropped with two samples in flight
        do_reset();
        i_ena = 1'b1;
        bi = iss_sel.size();
        br = res_ch.size();
        set_req(4'b0011, 21, 22, 0, 0);
        tick();
        i_req = '0;
        tick(2);
        check("t5_ena_second", core_if.o_core_ena, 1);
        check("t5_sel_second", core_if.o_core_sel, 1);
        i_ena = 1'b0;
        tick();
        check("t5_busy_drain0", o_busy, 1);
        check("t5_valid0", o_valid, 1);
        check("t5_ch0", o_ch, 0);
        check("t5_data0", o_data, 63);
        tick();
        check("t5_busy_drain1", o_busy, 1);
        check("t5_no_new_ena", core_if.o_core_ena, 0);
        check("t5_valid1", o_valid, 1);
        check("t5_ch1", o_ch, 1);
        check("t5_data1", o_data, 66);
        tick();
        check("t5_busy_fall", o_busy, 0);
        tick(3);
        check("t5_n_iss", iss_sel.size() - bi, 2);
        check("t5_n_res", res_ch.size() - br, 2);

        // 6: asynchronous reset mid-burst
        do_reset();
        i_ena = 1'b1;
        set_req(4'b1111, 1, 2, 3, 4);
        tick();
        i_req = '0;
        tick(4);
        check("t6_pre_valid", o_valid, 1);
        check("t6_pre_data", o_data, 6);
        #2;
        rst_n = 1'b0;
        #1;
        check_outputs_zero("t6_rst");
        tick();
        rst_n = 1'b1;
        br = res_ch.size();
        bi = iss_sel.size();
        tick(6);
        check("t6_no_res_after", res_ch.size() - br, 0);
        check("t6_no_iss_after", iss_sel.size() - bi, 0);
        set_req(4'b0100, 0, 0, 7, 0);
        tick();
        i_req = '0;
        tick(5);
        check_iss("t6_new_iss", bi, 2, 7);
        check_res("t6_new_res", br, 2, 21);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
